// File: rtl/bcd2bin_seq_n.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Each conversion shifts {bcd, bin} right one bit W times. Between shifts, every BCD digit
// that is 8 or more has 3 subtracted. Results are registered and held until the next start.
// Optional feature: define BCD2BIN_DIGCHK_EN to reject inputs with nibbles above 9
// (err=1, bin_out=0, fast completion).
module bcd2bin_seq_n #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [4*DIGITS-1:0]   bin_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned CW = $clog2(W) + 1;

   typedef enum logic [1:0] {StIdle, StShift, StAdj, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    bcd_q;
   logic [W-1:0]    bin_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    bcd_adj;
   logic [CW-1:0]   cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   // Per-digit correction: a digit >= 8 after a right shift carries a half-ten from above.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_q[4*i+3]) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] - 4'd3;
         end
      end
   end

`ifdef BCD2BIN_DIGCHK_EN
   logic bad_digit;
   logic err_q;

   // Flag any input nibble outside 0..9.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         bin_out <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef BCD2BIN_DIGCHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  bcd_q <= bcd_in;
                  bin_q <= '0;
                  cnt_q <= '0;
`ifdef BCD2BIN_DIGCHK_EN
                  err_q <= bad_digit;
                  if (bad_digit) begin
                     // bin_q is cleared, so DONE publishes zero.
                     state_q <= StDone;
                  end else begin
                     state_q <= StShift;
                     busy    <= 1'b1;
                  end
`else
                  state_q <= StShift;
                  busy    <= 1'b1;
`endif
               end
            end
            StShift: begin
               bin_q <= {bcd_q[0], bin_q[W-1:1]};
               bcd_q <= {1'b0, bcd_q[W-1:1]};
               cnt_q <= cnt_inc;
               if (cnt_inc == CW'(W)) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
               end else begin
                  state_q <= StAdj;
               end
            end
            StAdj: begin
               bcd_q   <= bcd_adj;
               state_q <= StShift;
            end
            StDone: begin
               bin_out <= bin_q;
               done    <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq_n.sv
// Scoreboard bench for bcd2bin_seq_n: driver pushes expected results, monitor checks on done.
module tb_bcd2bin_seq_n;

   localparam int W  = 16;
   localparam int W2 = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  bcd_in;
   logic [W-1:0]  bin_out;
   logic          busy, done, err;
   logic          start2;
   logic [W2-1:0] bcd2;
   logic [W2-1:0] bin2;
   logic          busy2, done2, err2;

   bcd2bin_seq_n #(.DIGITS(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .bin_out(bin_out), .busy(busy), .done(done), .err(err)
   );

   bcd2bin_seq_n #(.DIGITS(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
      .bin_out(bin2), .busy(busy2), .done(done2), .err(err2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bin;
      logic        err;
      int          at;
   } exp_t;

   exp_t q[$];
   exp_t q2[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compare each done pulse against the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         check("done_busy_excl", {31'd0, busy}, 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            check("bin_out", {16'd0, bin_out}, {16'd0, e.bin});
            check("err", {31'd0, err}, {31'd0, e.err});
            check("done_cycle", cyc, e.at);
         end
      end
      if (!rst && done2) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done2: got done=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            e = q2.pop_front();
            check("bin_out_d2", {24'd0, bin2}, {16'd0, e.bin});
            check("done_cycle_d2", cyc, e.at);
         end
      end
   end

   // Called at a negedge; start is sampled on the following posedge.
   task automatic issue(input logic [15:0] v, input logic [15:0] exp, input logic e);
      start  = 1'b1;
      bcd_in = v;
      q.push_back('{bin: exp, err: e, at: cyc + 1 + 2 * W});
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic drain(output int nbusy);
      int n;
      nbusy = 0;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         if (busy) nbusy++;
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", q.size());
         q.delete();
      end
   endtask

   typedef struct {
      logic [15:0] bcd;
      logic [15:0] bin;
   } vec_t;

   vec_t vecs[4] = '{'{16'h8000, 16'h1F40}, '{16'h0010, 16'h000A},
                     '{16'h4096, 16'h1000}, '{16'h0099, 16'h0063}};

   initial begin
      int nb;
      int n;
      rst    = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      start2 = 1'b0;
      bcd2   = '0;
      repeat (3) @(negedge clk);
      check("rst_bin_out", {16'd0, bin_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Max value, with busy duration.
      issue(16'h9999, 16'h270F, 1'b0);
      drain(nb);
      check("busy_cycles", nb, 31);

      // Back-to-back: second start in the IDLE cycle carrying done.
      issue(16'h1234, 16'h04D2, 1'b0);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      start  = 1'b1;
      bcd_in = 16'h0000;
      q.push_back('{bin: 16'h0000, err: 1'b0, at: cyc + 1 + 2 * W});
      @(negedge clk);
      start = 1'b0;
      drain(nb);

      // Start held high: one accepted now, the next 33 cycles later.
      start  = 1'b1;
      bcd_in = 16'h0050;
      q.push_back('{bin: 16'h0032, err: 1'b0, at: cyc + 1 + 2 * W});
      q.push_back('{bin: 16'h0032, err: 1'b0, at: cyc + 1 + 33 + 2 * W});
      repeat (40) @(negedge clk);
      start = 1'b0;
      drain(nb);
      repeat (4) @(negedge clk);
      check("bin_out_hold", {16'd0, bin_out}, 32'h0032);

      // Reset wins over start in the same cycle.
      rst    = 1'b1;
      start  = 1'b1;
      bcd_in = 16'h9999;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_prio_busy", {31'd0, busy}, 32'd0);

      // Abort mid-conversion; no done pulse may follow.
      start  = 1'b1;
      bcd_in = 16'h4321;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_bin_out", {16'd0, bin_out}, 32'd0);
      check("abort_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      issue(16'h0007, 16'h0007, 1'b0);
      drain(nb);

      foreach (vecs[i]) begin
         issue(vecs[i].bcd, vecs[i].bin, 1'b0);
         drain(nb);
      end

`ifdef BCD2BIN_DIGCHK_EN
      // Invalid digit: done one clock after the sampling edge.
      start  = 1'b1;
      bcd_in = 16'h12A4;
      q.push_back('{bin: 16'h0000, err: 1'b1, at: cyc + 2});
      @(negedge clk);
      start = 1'b0;
      drain(nb);
      repeat (3) @(negedge clk);
      check("err_hold", {31'd0, err}, 32'd1);
      issue(16'h0001, 16'h0001, 1'b0);
      drain(nb);
`endif

      // Two-digit instance.
      start2 = 1'b1;
      bcd2   = 8'h99;
      q2.push_back('{bin: 16'h0063, err: 1'b0, at: cyc + 1 + 2 * W2});
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (q2.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q2.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_d2: got %0d pending results expected 0", q2.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
